// File: rtl/load_wb_scheduler.sv
// load_wb_scheduler
// Purpose: tracks outstanding loads in issue order and pairs each in-order
// memory response with its saved destination register, extraction selector
// and byte offset. Drives the external byte/half-word extraction unit and
// arbitrates the single register-file write port between load returns
// (absolute priority) and ALU results.
//
// Optional feature macro: LOAD_WB_SCOREBOARD_EN
//   defined   : hz_stall flags a stage-2 source that matches a pending load rd
//   undefined : hz_stall is tied 0 (issue logic waits for outstanding == 0)
//
// Ports:
//   clk, reset                     rising-edge clock, async active-high reset
//   ld_issue_valid/ready/rd/sel/byte   load issue handshake and saved fields
//   mem_resp_valid, mem_resp_data  in-order load response (never stalled)
//   ext_sel, ext_byte, ext_rdata   to extraction unit (combinational)
//   ext_result                     extended data back from extraction unit
//   alu_wb_valid/rd/data, alu_wb_stall  ALU write-back request and hold
//   rf_we, rf_waddr, rf_wdata      registered register-file write port
//   outstanding                    loads in flight
//   resp_err                       sticky: response with nothing outstanding
//   hz_rs1, hz_rs2, hz_stall       stage-2 load-use hazard check

`ifndef CPU_DATA_BITS
`define CPU_DATA_BITS 32
`endif

module load_wb_scheduler #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      ld_issue_valid,
   output logic                      ld_issue_ready,
   input  logic [4:0]                ld_issue_rd,
   input  logic [2:0]                ld_issue_sel,
   input  logic [1:0]                ld_issue_byte,

   input  logic                      mem_resp_valid,
   input  logic [`CPU_DATA_BITS-1:0] mem_resp_data,

   output logic [2:0]                ext_sel,
   output logic [1:0]                ext_byte,
   output logic [`CPU_DATA_BITS-1:0] ext_rdata,
   input  logic [`CPU_DATA_BITS-1:0] ext_result,

   input  logic                      alu_wb_valid,
   input  logic [4:0]                alu_wb_rd,
   input  logic [`CPU_DATA_BITS-1:0] alu_wb_data,
   output logic                      alu_wb_stall,

   output logic                      rf_we,
   output logic [4:0]                rf_waddr,
   output logic [`CPU_DATA_BITS-1:0] rf_wdata,

   output logic [CNT_W-1:0]          outstanding,
   output logic                      resp_err,

   input  logic [4:0]                hz_rs1,
   input  logic [4:0]                hz_rs2,
   output logic                      hz_stall
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned DATA_W = `CPU_DATA_BITS;

   typedef struct packed {
      logic [4:0] rd;
      logic [2:0] sel;
      logic [1:0] byte_sel;
   } tag_t;

   tag_t              fifo [DEPTH];
   tag_t              head;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;
   logic              fifo_empty;
   logic              push;
   logic              pop;

   logic              we_nxt;
   logic [4:0]        waddr_nxt;
   logic [DATA_W-1:0] wdata_nxt;

   // Handshake qualifiers; ready is conservative and ignores a same-cycle pop
   assign fifo_empty     = (count == '0);
   assign ld_issue_ready = (count != CNT_W'(DEPTH));
   assign push           = ld_issue_valid & ld_issue_ready;
   assign pop            = mem_resp_valid & ~fifo_empty;
   assign outstanding    = count;

   // Head fields go straight to the extraction unit; zero when nothing pending
   assign head      = fifo_empty ? '0 : fifo[rd_ptr];
   assign ext_sel   = head.sel;
   assign ext_byte  = head.byte_sel;
   assign ext_rdata = mem_resp_data;

   // A response always wins the write port, even an erroneous one
   assign alu_wb_stall = mem_resp_valid & alu_wb_valid;

   // Tag storage: data only, validity is tracked by count
   always_ff @(posedge clk) begin
      if (push) begin
         fifo[wr_ptr] <= '{rd: ld_issue_rd, sel: ld_issue_sel, byte_sel: ld_issue_byte};
      end
   end

   // Occupancy update
   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_nxt;
         if (push) begin
            wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
         end
         if (pop) begin
            rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
         end
      end
   end

   // Write-port select; address/data hold when no write is taken
   always_comb begin
      we_nxt    = 1'b0;
      waddr_nxt = rf_waddr;
      wdata_nxt = rf_wdata;
      if (mem_resp_valid) begin
         // an unmatched response writes nothing but still blocks the ALU
         if (pop && (head.rd != 5'd0)) begin
            we_nxt    = 1'b1;
            waddr_nxt = head.rd;
            wdata_nxt = ext_result;
         end
      end else if (alu_wb_valid && (alu_wb_rd != 5'd0)) begin
         we_nxt    = 1'b1;
         waddr_nxt = alu_wb_rd;
         wdata_nxt = alu_wb_data;
      end
   end

   // Registered write port and sticky error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         resp_err <= 1'b0;
      end else begin
         rf_we    <= we_nxt;
         rf_waddr <= waddr_nxt;
         rf_wdata <= wdata_nxt;
         if (mem_resp_valid && fifo_empty) begin
            resp_err <= 1'b1;
         end
      end
   end

`ifdef LOAD_WB_SCOREBOARD_EN
   function automatic logic src_hit(input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2);
      return ((rs1 != 5'd0) && (rs1 == rd)) || ((rs2 != 5'd0) && (rs2 == rd));
   endfunction

   // Entry i is valid when its distance from the read pointer is below count
   always_comb begin
      hz_stall = push & src_hit(ld_issue_rd, hz_rs1, hz_rs2);
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count) &&
             src_hit(fifo[i].rd, hz_rs1, hz_rs2)) begin
            hz_stall = 1'b1;
         end
      end
   end
`else
   logic unused_hz;

   assign unused_hz = ^{hz_rs1, hz_rs2};
   assign hz_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_load_wb_scheduler.sv
// tb_load_wb_scheduler
// Purpose: self-checking bench for load_wb_scheduler. A reference model of
// the tag FIFO predicts handshake/hazard outputs each cycle; expected
// register-file writes are queued with their due cycle and compared when
// rf_we appears. The bench also plays the external extraction unit.

module tb_load_wb_scheduler;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned DW    = 32;

   localparam logic [2:0] SEL_WORD   = 3'd0;
   localparam logic [2:0] SEL_BYTE_S = 3'd1;
   localparam logic [2:0] SEL_BYTE_U = 3'd2;
   localparam logic [2:0] SEL_HALF_S = 3'd3;
   localparam logic [2:0] SEL_HALF_U = 3'd4;

   logic             clk;
   logic             reset;
   logic             ld_issue_valid;
   logic             ld_issue_ready;
   logic [4:0]       ld_issue_rd;
   logic [2:0]       ld_issue_sel;
   logic [1:0]       ld_issue_byte;
   logic             mem_resp_valid;
   logic [DW-1:0]    mem_resp_data;
   logic [2:0]       ext_sel;
   logic [1:0]       ext_byte;
   logic [DW-1:0]    ext_rdata;
   logic [DW-1:0]    ext_result;
   logic             alu_wb_valid;
   logic [4:0]       alu_wb_rd;
   logic [DW-1:0]    alu_wb_data;
   logic             alu_wb_stall;
   logic             rf_we;
   logic [4:0]       rf_waddr;
   logic [DW-1:0]    rf_wdata;
   logic [CNT_W-1:0] outstanding;
   logic             resp_err;
   logic [4:0]       hz_rs1;
   logic [4:0]       hz_rs2;
   logic             hz_stall;

   typedef struct {
      logic [4:0] rd;
      logic [2:0] sel;
      logic [1:0] b;
   } ld_t;

   typedef struct {
      int            due;
      logic [4:0]    a;
      logic [DW-1:0] d;
   } wr_t;

   ld_t mdl_q[$];
   wr_t exp_q[$];
   bit  m_err;
   int  cyc;
   int  n_cmp;
   int  n_err;

   load_wb_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .ld_issue_valid (ld_issue_valid),
      .ld_issue_ready (ld_issue_ready),
      .ld_issue_rd    (ld_issue_rd),
      .ld_issue_sel   (ld_issue_sel),
      .ld_issue_byte  (ld_issue_byte),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .ext_sel        (ext_sel),
      .ext_byte       (ext_byte),
      .ext_rdata      (ext_rdata),
      .ext_result     (ext_result),
      .alu_wb_valid   (alu_wb_valid),
      .alu_wb_rd      (alu_wb_rd),
      .alu_wb_data    (alu_wb_data),
      .alu_wb_stall   (alu_wb_stall),
      .rf_we          (rf_we),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata),
      .outstanding    (outstanding),
      .resp_err       (resp_err),
      .hz_rs1         (hz_rs1),
      .hz_rs2         (hz_rs2),
      .hz_stall       (hz_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Extraction unit behaviour (sign/zero extend selected byte or half-word)
   function automatic logic [DW-1:0] extract(input logic [2:0] s, input logic [1:0] b,
                                             input logic [DW-1:0] d);
      logic [DW-1:0] sh;
      sh = d >> {b, 3'b000};
      case (s)
         SEL_BYTE_S: return {{24{sh[7]}}, sh[7:0]};
         SEL_BYTE_U: return {24'd0, sh[7:0]};
         SEL_HALF_S: return {{16{sh[15]}}, sh[15:0]};
         SEL_HALF_U: return {16'd0, sh[15:0]};
         default:    return d;
      endcase
   endfunction

   assign ext_result = extract(ext_sel, ext_byte, ext_rdata);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit hit(input logic [4:0] rd);
      return ((hz_rs1 != 5'd0) && (hz_rs1 == rd)) || ((hz_rs2 != 5'd0) && (hz_rs2 == rd));
   endfunction

   function automatic bit model_hz();
      bit h;
      h = 1'b0;
`ifdef LOAD_WB_SCOREBOARD_EN
      foreach (mdl_q[i]) if (hit(mdl_q[i].rd)) h = 1'b1;
      if (ld_issue_valid && (mdl_q.size() != DEPTH) && hit(ld_issue_rd)) h = 1'b1;
`endif
      return h;
   endfunction

   task automatic idle();
      ld_issue_valid = 1'b0;
      ld_issue_rd    = '0;
      ld_issue_sel   = '0;
      ld_issue_byte  = '0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      alu_wb_valid   = 1'b0;
      alu_wb_rd      = '0;
      alu_wb_data    = '0;
   endtask

   // Check combinational outputs, update the model, then advance one cycle
   task automatic step();
      bit  push;
      ld_t h;
      #1;
      check("ready", ld_issue_ready, mdl_q.size() != DEPTH);
      check("outstanding", outstanding, mdl_q.size());
      check("resp_err", resp_err, m_err);
      check("alu_stall", alu_wb_stall, mem_resp_valid & alu_wb_valid);
      check("hz_stall", hz_stall, model_hz());
      push = ld_issue_valid && (mdl_q.size() != DEPTH);
      if (mem_resp_valid && mdl_q.size() != 0) begin
         h = mdl_q.pop_front();
         check("ext_sel", ext_sel, h.sel);
         check("ext_byte", ext_byte, h.b);
         check("ext_rdata", ext_rdata, mem_resp_data);
         if (h.rd != 5'd0)
            exp_q.push_back('{cyc + 1, h.rd, extract(h.sel, h.b, mem_resp_data)});
      end else if (mem_resp_valid) begin
         check("ext_sel_empty", ext_sel, 0);
         check("ext_byte_empty", ext_byte, 0);
         m_err = 1'b1;
      end else if (alu_wb_valid && alu_wb_rd != 5'd0) begin
         exp_q.push_back('{cyc + 1, alu_wb_rd, alu_wb_data});
      end
      if (push) mdl_q.push_back('{ld_issue_rd, ld_issue_sel, ld_issue_byte});
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mdl_q.delete();
      exp_q.delete();
      m_err = 1'b0;
      #1;
      check("rst_rf_we", rf_we, 0);
      check("rst_waddr", rf_waddr, 0);
      check("rst_wdata", rf_wdata, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_ready", ld_issue_ready, 1);
      check("rst_resp_err", resp_err, 0);
      check("rst_ext_sel", ext_sel, 0);
      check("rst_ext_byte", ext_byte, 0);
      check("rst_hz", hz_stall, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [2:0] sel, input logic [1:0] b);
      ld_issue_valid = 1'b1;
      ld_issue_rd    = rd;
      ld_issue_sel   = sel;
      ld_issue_byte  = b;
   endtask

   task automatic respond(input logic [DW-1:0] d);
      mem_resp_valid = 1'b1;
      mem_resp_data  = d;
   endtask

   // Scoreboard consumer: writes must match in order and land on their due cycle
   always @(negedge clk) begin
      wr_t w;
      if (!reset) begin
         if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            check("missing_wr_due", exp_q[0].due, cyc);
            void'(exp_q.pop_front());
         end
         if (rf_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_wr", rf_we, 0);
            end else begin
               w = exp_q.pop_front();
               check("wr_cycle", cyc, w.due);
               check("wr_addr", rf_waddr, w.a);
               check("wr_data", rf_wdata, w.d);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit            a_v;
      bit            stalled;
      logic [4:0]    a_rd;
      logic [DW-1:0] a_d;
      cyc    = 0;
      n_cmp  = 0;
      n_err  = 0;
      hz_rs1 = '0;
      hz_rs2 = '0;
      idle();
      do_reset();

      // single signed-byte load: 0x00800000, byte 2 -> 0xFFFFFF80 to r5
      issue(5'd5, SEL_BYTE_S, 2'd2);
      step();
      respond(32'h0080_0000);
      step();
      step();

      // fill to DEPTH; same-cycle response + issue is refused
      for (int i = 0; i < 4; i++) begin
         issue(5'(10 + i), SEL_HALF_U, 2'(i * 2));
         step();
      end
      issue(5'd20, SEL_WORD, 2'd0);
      respond(32'h1234_5678);
      step();
      for (int i = 0; i < 3; i++) begin
         respond(32'hA5C3_F00F ^ 32'(i));
         step();
      end
      step();

      // load and ALU collide: load first, held ALU result next cycle
      issue(5'd3, SEL_BYTE_U, 2'd1);
      step();
      respond(32'hDEAD_BEEF);
      alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 32'h0000_0777;
      step();
      alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 32'h0000_0777;
      step();
      step();

      // response with nothing outstanding: sticky error, no write
      respond(32'hFFFF_FFFF);
      alu_wb_valid = 1'b1; alu_wb_rd = 5'd8; alu_wb_data = 32'h88;
      step();
      alu_wb_valid = 1'b1; alu_wb_rd = 5'd8; alu_wb_data = 32'h88;
      step();
      step();
      step();
      do_reset();

      // load to r0 pops silently
      issue(5'd0, SEL_WORD, 2'd0);
      step();
      respond(32'h5555_5555);
      step();
      step();

      // pending r9 against hz_rs2 until popped
      issue(5'd9, SEL_WORD, 2'd0);
      hz_rs2 = 5'd9;
      step();
      step();
      step();
      respond(32'h0000_0009);
      step();
      step();
      hz_rs2 = '0;

      // reset with 3 pending and a write in flight
      for (int i = 0; i < 4; i++) begin
         issue(5'(1 + i), SEL_WORD, 2'd0);
         step();
      end
      respond(32'h0BAD_F00D);
      step();
      check("pre_rst_we", rf_we, 1);
      check("pre_rst_outstanding", outstanding, 3);
      do_reset();
      respond(32'h0000_0001);
      step();
      step();
      do_reset();

      // random traffic with ALU holding its result while stalled
      a_v = 1'b0; a_rd = '0; a_d = '0; stalled = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!stalled) begin
            a_v  = ($urandom_range(0, 2) == 0);
            a_rd = 5'($urandom);
            a_d  = $urandom;
         end
         if ($urandom_range(0, 1) == 1)
            issue(5'($urandom_range(0, 15)), 3'($urandom_range(0, 4)), 2'($urandom));
         if (mdl_q.size() != 0 && $urandom_range(0, 2) != 0)
            respond($urandom);
         hz_rs1 = 5'($urandom_range(0, 15));
         hz_rs2 = 5'($urandom_range(0, 15));
         alu_wb_valid = a_v;
         alu_wb_rd    = a_rd;
         alu_wb_data  = a_d;
         stalled = a_v && mem_resp_valid;
         step();
      end
      hz_rs1 = '0;
      hz_rs2 = '0;
      while (mdl_q.size() != 0) begin
         respond($urandom);
         step();
      end
      repeat (3) step();
      check("sb_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
